// File: rtl/ip_pkg.sv
// -----------------------------------------------------------------------------
// ip_pkg
// Shared IPv4 header definitions for the byte-serial transmit encoder and the
// receive-side decoder: fixed header constants, FSM state encoding, the latched
// header field bundle and a helper that returns 16-bit header word n.
// -----------------------------------------------------------------------------
package ip_pkg;

   localparam logic [3:0] IP_VERSION_4   = 4'h4;
   localparam logic [3:0] IP_IHL_MIN     = 4'h5;
   localparam int         IP_HDR_BYTES   = 20;
   localparam int         IP_CSUM_OFFSET = 10;   // byte offset of checksum MSB

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CSUM = 2'd1,
      ST_SEND = 2'd2
   } ip_state_e;

   typedef struct packed {
      logic [7:0]  dscp;
      logic [15:0] total_length;
      logic [15:0] id_code;
      logic [2:0]  flags;
      logic [12:0] frag_offset;
      logic [7:0]  ttl;
      logic [7:0]  protocol;
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
   } ip_hdr_t;

   // Header word n (0..9). Word 5 is the checksum field, which reads as zero
   // while the checksum itself is being computed.
   function automatic logic [15:0] ip_hdr_word(input ip_hdr_t h, input logic [3:0] idx);
      logic [15:0] w;
      case (idx)
         4'd0:    w = {IP_VERSION_4, IP_IHL_MIN, h.dscp};
         4'd1:    w = h.total_length;
         4'd2:    w = h.id_code;
         4'd3:    w = {h.flags, h.frag_offset};
         4'd4:    w = {h.ttl, h.protocol};
         4'd6:    w = h.src_ip[31:16];
         4'd7:    w = h.src_ip[15:0];
         4'd8:    w = h.dst_ip[31:16];
         4'd9:    w = h.dst_ip[15:0];
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/ip_csum_add16.sv
// -----------------------------------------------------------------------------
// ip_csum_add16
// Combinational 16-bit ones-complement addition with end-around carry, as used
// by the IPv4 header checksum.
//   a, b : 16-bit operands
//   sum  : ones-complement sum (carry out of bit 15 folded back into bit 0)
// -----------------------------------------------------------------------------
module ip_csum_add16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);

   logic [16:0] sum17;

   // The folded carry cannot ripple out again: the largest raw sum is 0x1FFFE,
   // whose low half plus one is still 0xFFFF.
   always_comb begin
      sum17 = {1'b0, a} + {1'b0, b};
      sum   = sum17[15:0] + {15'd0, sum17[16]};
   end

endmodule

// File: rtl/ip_encode_pri8.sv
// -----------------------------------------------------------------------------
// ip_encode_pri8
// Byte-serial IPv4 header encoder. A start pulse in IDLE latches the header
// fields; the checksum is then accumulated one 16-bit word per cycle (10
// cycles) and the 20-byte header is streamed MSB-first over valid/ready.
//
// Ports
//   clk, sync_reset        : clock, synchronous active-high reset
//   start                  : build request, honoured only in IDLE
//   dscp .. dstIp          : header fields, captured on the start edge
//   data_out               : header byte
//   data_out_valid/_ready  : handshake toward the frame assembler
//   data_out_last          : marks header byte 19
//   busy                   : high whenever not IDLE
//   header_done            : one-cycle pulse after the final byte is accepted
//   checkSum               : computed checksum, held until the next header
// -----------------------------------------------------------------------------
module ip_encode_pri8
   import ip_pkg::*;
#(
   parameter int AVL_SIZE  = 8,
   parameter int BYTE_SIZE = 8,
   parameter int IP_SIZE   = 32,
   parameter int HDR_WORDS = 10
) (
   input  logic                clk,
   input  logic                sync_reset,
   input  logic                start,
   input  logic [7:0]          dscp,
   input  logic [15:0]         totalLength,
   input  logic [15:0]         idCode,
   input  logic [2:0]          flags,
   input  logic [12:0]         fragmentOffset,
   input  logic [7:0]          timeToLive,
   input  logic [7:0]          protocol,
   input  logic [IP_SIZE-1:0]  srcIp,
   input  logic [IP_SIZE-1:0]  dstIp,
   output logic [AVL_SIZE-1:0] data_out,
   output logic                data_out_valid,
   input  logic                data_out_ready,
   output logic                data_out_last,
   output logic                busy,
   output logic                header_done,
   output logic [15:0]         checkSum
);

   localparam logic [3:0] LAST_WORD = 4'(HDR_WORDS - 1);
   localparam logic [4:0] LAST_BYTE = 5'(IP_HDR_BYTES - 1);
   localparam logic [4:0] CSUM_MSB  = 5'(IP_CSUM_OFFSET);
   localparam logic [4:0] CSUM_LSB  = 5'(IP_CSUM_OFFSET + 1);

   ip_state_e      state_q, state_d;
   ip_hdr_t        hdr_q;
   logic [3:0]     word_idx_q;
   logic [4:0]     byte_idx_q;
   logic [15:0]    acc_q;
   logic [15:0]    check_sum_q;
   logic           done_q;

   logic [15:0]    cur_word;
   logic [15:0]    acc_sum;
   logic [15:0]    tx_word;
   logic [BYTE_SIZE-1:0] hdr_byte;
   logic           send_hs;
   logic           last_byte;

   assign cur_word  = ip_hdr_word(hdr_q, word_idx_q);
   assign last_byte = (byte_idx_q == LAST_BYTE);
   assign send_hs   = (state_q == ST_SEND) && data_out_ready;

   ip_csum_add16 u_csum_add (
      .a   (acc_q),
      .b   (cur_word),
      .sum (acc_sum)
   );

   // Next-state logic.
   // NOTE: state_d is assigned a default before the case so no path through
   // this block leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)                    state_d = ST_CSUM;
         ST_CSUM: if (word_idx_q == LAST_WORD)  state_d = ST_SEND;
         ST_SEND: if (send_hs && last_byte)     state_d = ST_IDLE;
         default:                               state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   // NOTE: every register here is written with <= so all of them update from
   // the same pre-edge values; blocking writes would let later statements see
   // already-updated state.
   // NOTE: the field registers are reset along with control so a header
   // aborted by reset leaves no stale fields behind; they are flops, not RAM.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q     <= ST_IDLE;
         hdr_q       <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         acc_q       <= '0;
         check_sum_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  hdr_q      <= '{dscp:         dscp,
                                  total_length: totalLength,
                                  id_code:      idCode,
                                  flags:        flags,
                                  frag_offset:  fragmentOffset,
                                  ttl:          timeToLive,
                                  protocol:     protocol,
                                  src_ip:       srcIp,
                                  dst_ip:       dstIp};
                  word_idx_q <= '0;
                  acc_q      <= '0;
               end
            end
            ST_CSUM: begin
               acc_q      <= acc_sum;
               word_idx_q <= word_idx_q + 4'd1;
               if (word_idx_q == LAST_WORD) begin
                  check_sum_q <= ~acc_sum;
                  byte_idx_q  <= '0;
               end
            end
            ST_SEND: begin
               if (send_hs) begin
                  if (last_byte) done_q     <= 1'b1;
                  else           byte_idx_q <= byte_idx_q + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output byte is selected from registered fields/index only, so it cannot
   // move while the receiver stalls.
   always_comb begin
      tx_word  = ip_hdr_word(hdr_q, byte_idx_q[4:1]);
      hdr_byte = '0;
      if (state_q == ST_SEND) begin
         if (byte_idx_q == CSUM_MSB)      hdr_byte = check_sum_q[15:8];
         else if (byte_idx_q == CSUM_LSB) hdr_byte = check_sum_q[7:0];
         else if (byte_idx_q[0])          hdr_byte = tx_word[7:0];
         else                             hdr_byte = tx_word[15:8];
      end
   end

   assign data_out       = hdr_byte;
   assign data_out_valid = (state_q == ST_SEND);
   assign data_out_last  = (state_q == ST_SEND) && last_byte;
   assign busy           = (state_q != ST_IDLE);
   assign header_done    = done_q;
   assign checkSum       = check_sum_q;

endmodule

// File: doc/ip_encode_pri8.md
Name: ip_encode_pri8

Overview:
- Byte-serial IPv4 header encoder; the transmit-side counterpart of the byte-wide IP header decoder in the udp_core8 receive path.
- Latches header fields on a start pulse, computes the header checksum sequentially, then streams a 20-byte IPv4 header (version 4, IHL 5, no options) MSB-first.
- Uses a valid/ready handshake toward the Ethernet frame assembler.

Parameters:
- AVL_SIZE, 8, output data width in bits (only 8 supported).
- BYTE_SIZE, 8, bits per byte.
- IP_SIZE, 32, IPv4 address width.
- HDR_WORDS, 10, number of 16-bit header words (20 bytes).

Ports:
- clk  input  1  system clock.
- sync_reset  input  1  synchronous reset, active-high.
- start  input  1  request to build a header; sampled only in IDLE.
- dscp  input  8  DSCP/ECN byte.
- totalLength  input  16  IP total length.
- idCode  input  16  identification.
- flags  input  3  flags.
- fragmentOffset  input  13  fragment offset.
- timeToLive  input  8  TTL.
- protocol  input  8  protocol number.
- srcIp  input  32  source address.
- dstIp  input  32  destination address.
- data_out  output  8  header byte.
- data_out_valid  output  1  data_out is valid.
- data_out_ready  input  1  downstream accepts the byte.
- data_out_last  output  1  marks byte 19.
- busy  output  1  high in any state other than IDLE.
- header_done  output  1  one-cycle pulse after the final byte is accepted.
- checkSum  output  16  computed checksum; held until the next start.

Behaviour:
- Reset values: state IDLE; data_out=0, data_out_valid=0, data_out_last=0, busy=0, header_done=0, checkSum=0, field registers=0. Reset mid-CSUM or mid-SEND aborts immediately, emits no further bytes and no header_done.
- States: IDLE, CSUM, SEND.
- IDLE:
  - On start=1, all input fields are latched at that edge.
  - Word index cleared, accumulator cleared, go to CSUM.
  - start is ignored in CSUM and SEND.
- CSUM (exactly 10 cycles), summing words w0..w9:
  - w0 = {4'h4,4'h5,dscp}
  - w1 = totalLength
  - w2 = idCode
  - w3 = {flags,fragmentOffset}
  - w4 = {timeToLive,protocol}
  - w5 = 16'h0000 (checksum field)
  - w6 = srcIp[31:16], w7 = srcIp[15:0]
  - w8 = dstIp[31:16], w9 = dstIp[15:0]
  - Each cycle: sum17 = acc + w[idx]; acc <= sum17[15:0] + sum17[16] (end-around carry, 16-bit result).
  - After w9 is added: checkSum <= ~acc_final, byte index cleared, go to SEND.
- SEND:
  - data_out_valid=1. data_out = header byte[byte_idx]; bytes 10/11 = checkSum[15:8]/[7:0], all others are the MSB-first bytes of w0..w9.
  - byte_idx advances only when data_out_valid && data_out_ready. While ready=0, data_out holds stable; there is no timeout.
  - data_out_last=1 when byte_idx==19.
  - On the handshake of byte 19: go to IDLE, data_out_valid drops next cycle, header_done=1 for exactly the next cycle.
- Latency:
  - Start sampled at edge T; busy=1 from T+1.
  - First valid byte at cycle T+11.
  - With ready held high, the last byte is accepted at T+30 and header_done is high during T+31.
- Back-to-back: a start during the final-handshake cycle is ignored. The earliest accepted start is the cycle in which header_done is high, and that start is accepted.
- data_out is registered or driven from registered state/index only. There is no combinational path from data_out_ready to data_out_valid.

Decomposition:
- Shared package/include (ip_pkg):
  - IP_VERSION_4 = 4'h4, IP_IHL_MIN = 4'h5, IP_HDR_BYTES = 20.
  - State encodings (IDLE/CSUM/SEND).
  - Header byte offsets: checksum at 10.
  - Shared with the receive-side decoder.
- One sub-module, ip_csum_add16: combinational 16-bit ones-complement add with end-around carry. Instantiated once here and reusable by checksum verification on the receive path.

Test Plan:
- Standard header:
  - Stimulus: dscp=00, totalLength=0073, idCode=0000, flags=3'b010, frag=0, ttl=40, protocol=11, src=C0A80001, dst=C0A800C7, ready=1.
  - Required response: bytes 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7; checkSum=B861; first valid at T+11; last flagged on byte 19; header_done at T+31.
- Carry wrap:
  - Stimulus: dscp=FF, totalLength=FFFF, idCode=FFFF, flags=7, frag=1FFF, ttl=FF, protocol=FF, src=FFFFFFFF, dst=FFFFFFFF.
  - Required response: checkSum=BA00, bytes 10/11 = BA 00.
- Backpressure:
  - Stimulus: standard header with ready toggling 1,0,0,1 repeating.
  - Required response: identical 20-byte sequence, data_out stable while ready=0, exactly 20 handshakes, single header_done.
- Start while busy and back-to-back:
  - Stimulus: pulse start with different fields during CSUM and during SEND, then assert start in the header_done cycle.
  - Required response: the first two starts are ignored and the first header is unchanged; the third start begins a new header with first valid 11 cycles later.
- Reset mid-SEND:
  - Stimulus: assert sync_reset after byte 7 is accepted.
  - Required response: next cycle data_out_valid=0, busy=0, checkSum=0, no header_done; a subsequent start produces a full correct header.
- Field latching:
  - Stimulus: change all field inputs on the cycle after start.
  - Required response: emitted header reflects the values captured at the start edge.
